// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, NOP encoding,
// halt-cause codes and fetch FSM states.
package if_stage_pkg;

    localparam int WORD_W      = 32;
    localparam int IMEM_ADDR_W = 10;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        HALT_NONE  = 2'b00,
        HALT_RANGE = 2'b01,
        HALT_ALIGN = 2'b10
    } halt_cause_e;

    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_HALT = 1'b1
    } if_state_e;

    function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds on stall, or
// collapses to a bubble (valid=0, NOP) on squash/halt.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_pc_plus4,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_pc_plus4
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_instr    <= NOP_INSTR;
            o_pc       <= '0;
            o_pc_plus4 <= '0;
        end else if (i_bubble) begin
            // PC fields are left as-is; they carry no meaning while o_valid=0.
            o_valid <= 1'b0;
            o_instr <= NOP_INSTR;
        end else if (i_load) begin
            o_valid    <= 1'b1;
            o_instr    <= i_instr;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc_plus4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, redirect/range
// checks, RUN/HALT FSM, delivered-instruction counter and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [WORD_W-1:0]      redirect_pc,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [WORD_W-1:0]      imem_data,
    output logic                   id_valid,
    output logic [WORD_W-1:0]      id_instr,
    output logic [WORD_W-1:0]      id_pc,
    output logic [WORD_W-1:0]      id_pc_plus4,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [WORD_W-1:0]      fetch_count
);

    localparam logic [WORD_W-1:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

    if_state_e         r_state;
    halt_cause_e       r_halt_cause;
    logic              r_halted;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_fetch_count;

    logic              w_pc_plus4;
    logic [WORD_W-1:0] w_pc_next_seq;
    logic              w_redir_aligned;
    logic              w_redir_in_range;
    logic              w_pc_in_range;
    logic              w_load;
    logic              w_bubble;

    assign w_pc_next_seq    = r_pc + 32'd4;
    assign w_redir_aligned  = word_aligned(redirect_pc);
    assign w_redir_in_range = redirect_pc < PC_LIMIT;
    assign w_pc_in_range    = r_pc < PC_LIMIT;
    assign w_pc_plus4       = 1'b0;

    // IF/ID control; in HALT the register already holds a bubble and just keeps it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_load   = 1'b0;
        w_bubble = 1'b0;
        if (r_state == IF_RUN) begin
            if (redirect_valid || !w_pc_in_range) begin
                w_bubble = 1'b1;
            end else if (!stall) begin
                w_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state       <= IF_RUN;
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_halt_cause  <= HALT_NONE;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                IF_RUN: begin
                    if (redirect_valid) begin
                        if (!w_redir_aligned) begin
                            r_state      <= IF_HALT;
                            r_halted     <= 1'b1;
                            r_halt_cause <= HALT_ALIGN;
                        end else if (!w_redir_in_range) begin
                            r_state      <= IF_HALT;
                            r_halted     <= 1'b1;
                            r_halt_cause <= HALT_RANGE;
                        end else begin
                            r_pc <= redirect_pc;
                        end
                    end else if (!w_pc_in_range) begin
                        r_state      <= IF_HALT;
                        r_halted     <= 1'b1;
                        r_halt_cause <= HALT_RANGE;
                    end else if (!stall) begin
                        r_pc          <= w_pc_next_seq;
                        r_fetch_count <= r_fetch_count + 32'd1;
                    end
                end
                IF_HALT: begin
                    if (redirect_valid) begin
                        if (w_redir_aligned && w_redir_in_range) begin
                            r_state      <= IF_RUN;
                            r_pc         <= redirect_pc;
                            r_halted     <= 1'b0;
                            r_halt_cause <= HALT_NONE;
                        end else if (!w_redir_aligned) begin
                            r_halt_cause <= HALT_ALIGN;
                        end else begin
                            r_halt_cause <= HALT_RANGE;
                        end
                    end
                end
                default: r_state <= IF_HALT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_instr    (imem_data),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_next_seq | {31'd0, w_pc_plus4}),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc       (id_pc),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign imem_addr   = r_pc[11:2];
    assign halted      = r_halted;
    assign halt_cause  = r_halt_cause;
    assign fetch_count = r_fetch_count;

endmodule
